// File: rtl/step_clock_ctrl.sv
// step_clock_ctrl: BUFGCE enable sequencer for free-run, exact stepping and readback capture.
// Optional HALT_TRIGGER_EN macro enables halt_req breakpoints that end RUN/STEP early.
module step_clock_ctrl #(
  parameter int CNT_W         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             halt_req,
  output logic             clk_ce,
  output logic             capture,
  input  logic             capture_done,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] cycles_run
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RUN      = 3'd1;
  localparam logic [2:0] STEP     = 3'd2;
  localparam logic [2:0] SETTLE   = 3'd3;
  localparam logic [2:0] CAPTURE  = 3'd4;
  localparam logic [2:0] WAIT_ACK = 3'd5;

  logic [2:0]       state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       scnt;
  logic             cap_flag, halt, fire, clear;

`ifdef HALT_TRIGGER_EN
  assign halt = halt_req && (state == RUN || state == STEP);
  always_ff @(posedge clk or posedge rst)
    if (rst) halted <= 1'b0;
    else halted <= fire ? 1'b0 : (halt ? 1'b1 : halted);
`else
  logic unused_halt_req;
  assign unused_halt_req = halt_req;
  assign halt = 1'b0;
  assign halted = 1'b0;
`endif

  assign cmd_ready = !rst && (state == IDLE || state == RUN) && !halt;
  assign fire      = cmd_valid && cmd_ready;
  assign clear     = fire && (cmd_op[1] || (cmd_op == 2'b01 && state == IDLE));
  assign busy      = state != IDLE;
  assign capture   = state == CAPTURE;

  always_comb begin
    state_n = state;
    if (halt) state_n = (state == STEP && cap_flag) ? SETTLE : IDLE;
    else if (fire) state_n = cmd_op == 2'b00 ? IDLE :
                             cmd_op == 2'b01 ? RUN :
                             cmd_count != '0 ? STEP :
                             cmd_op[0] ? SETTLE : IDLE;
    else if (state == STEP && cnt == '0) state_n = cap_flag ? SETTLE : IDLE;
    else if (state == SETTLE && scnt == 8'd0) state_n = CAPTURE;
    else if (state == CAPTURE) state_n = WAIT_ACK;
    else if (state == WAIT_ACK && capture_done) state_n = IDLE;
  end

  // CE is high for every cycle the run state persists, one cycle behind the state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      clk_ce     <= 1'b0;
      cnt        <= '0;
      scnt       <= 8'(SETTLE_CYCLES - 1);
      cap_flag   <= 1'b0;
      cycles_run <= '0;
    end else begin
      state  <= state_n;
      clk_ce <= (state == RUN || state == STEP) && state_n == state;
      if (fire && cmd_op[1]) begin
        cnt      <= cmd_count;
        cap_flag <= cmd_op[0];
      end else if (state == STEP && cnt != '0) cnt <= cnt - CNT_W'(1);
      scnt       <= state == SETTLE ? scnt - 8'd1 : 8'(SETTLE_CYCLES - 1);
      cycles_run <= clear ? '0 : (clk_ce && !(&cycles_run)) ? cycles_run + CNT_W'(1) : cycles_run;
    end
endmodule

// File: tb/tb_step_clock_ctrl.sv
// tb_step_clock_ctrl: directed self-checking bench for step_clock_ctrl (both HALT_TRIGGER_EN builds).
module tb_step_clock_ctrl;
  logic        clk = 0, rst = 1;
  logic        cmd_valid = 0, cmd_ready, halt_req = 0, clk_ce, capture, capture_done = 0, busy, halted;
  logic [1:0]  cmd_op = 0;
  logic [31:0] cmd_count = 0, cycles_run;
  logic        cmd_valid4 = 0, cmd_ready4, clk_ce4, capture4, busy4, halted4;
  logic [1:0]  cmd_op4 = 0;
  logic [3:0]  cmd_count4 = 0, cycles_run4;
  int          checks = 0, errors = 0, cap_cnt = 0, cap0;

  always #5 clk = ~clk;
  always @(negedge clk) if (capture) cap_cnt++;

  step_clock_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_count(cmd_count), .halt_req(halt_req), .clk_ce(clk_ce), .capture(capture),
    .capture_done(capture_done), .busy(busy), .halted(halted), .cycles_run(cycles_run)
  );

  step_clock_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4), .cmd_op(cmd_op4),
    .cmd_count(cmd_count4), .halt_req(1'b0), .clk_ce(clk_ce4), .capture(capture4),
    .capture_done(1'b0), .busy(busy4), .halted(halted4), .cycles_run(cycles_run4)
  );

  task tick();
    @(posedge clk);
    #1;
  endtask

  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task cmd(input logic [1:0] op, input logic [31:0] n);
    cmd_valid = 1; cmd_op = op; cmd_count = n;
    tick();
    cmd_valid = 0;
  endtask

  task cmd4(input logic [1:0] op, input logic [3:0] n);
    cmd_valid4 = 1; cmd_op4 = op; cmd_count4 = n;
    tick();
    cmd_valid4 = 0;
  endtask

  initial begin
    #1;
    chk("rst_ce", clk_ce, 0); chk("rst_cap", capture, 0); chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0); chk("rst_halted", halted, 0); chk("rst_cycles", cycles_run, 0);
    tick(); tick();
    rst = 0;
    tick();
    chk("ready_after_rst", cmd_ready, 1);

    cmd(2'b10, 5);
    chk("step5_lat_ce", clk_ce, 0); chk("step5_busy", busy, 1); chk("step5_ready", cmd_ready, 0);
    for (int i = 0; i < 5; i++) begin tick(); chk("step5_ce", clk_ce, 1); end
    tick();
    chk("step5_ce_off", clk_ce, 0); chk("step5_busy_off", busy, 0);
    chk("step5_cycles", cycles_run, 5); chk("step5_nocap", cap_cnt, 0);

    cmd(2'b11, 3);
    chk("sc_lat_ce", clk_ce, 0);
    for (int i = 0; i < 3; i++) begin tick(); chk("sc_ce", clk_ce, 1); chk("sc_ready", cmd_ready, 0); end
    for (int i = 0; i < 4; i++) begin
      tick(); chk("sc_settle_ce", clk_ce, 0); chk("sc_settle_cap", capture, 0); chk("sc_settle_ready", cmd_ready, 0);
    end
    tick();
    chk("sc_cap", capture, 1);
    capture_done = 1;
    tick();
    capture_done = 0;
    chk("sc_cap_off", capture, 0); chk("sc_early_ack_ignored", busy, 1);
    repeat (5) tick();
    chk("sc_wait_busy", busy, 1); chk("sc_wait_ready", cmd_ready, 0);
    capture_done = 1;
    tick();
    capture_done = 0;
    chk("sc_done_busy", busy, 0); chk("sc_done_ready", cmd_ready, 1); chk("sc_cap_count", cap_cnt, 1);

    cmd(2'b01, 0);
    repeat (100) tick();
    chk("run_ce", clk_ce, 1); chk("run_ready", cmd_ready, 1);
    cmd(2'b00, 0);
    chk("stop_ce", clk_ce, 0); chk("stop_cycles", cycles_run, 100); chk("stop_busy", busy, 0);
    tick();
    chk("stop_ce2", clk_ce, 0); chk("stop_cycles2", cycles_run, 100);
    cmd(2'b10, 0);
    chk("step0_busy", busy, 0); chk("step0_cycles", cycles_run, 0);
    repeat (3) tick();
    chk("step0_ce", clk_ce, 0); chk("step0_cycles2", cycles_run, 0);

    cmd4(2'b01, 0);
    repeat (40) tick();
    chk("sat_cycles", cycles_run4, 15); chk("sat_ce", clk_ce4, 1);
    cmd4(2'b10, 2);
    chk("sat_step_clear", cycles_run4, 0); chk("sat_step_ce0", clk_ce4, 0);
    tick(); chk("sat_step_ce1", clk_ce4, 1);
    tick(); chk("sat_step_ce2", clk_ce4, 1);
    tick();
    chk("sat_step_end_ce", clk_ce4, 0); chk("sat_step_cycles", cycles_run4, 2); chk("sat_step_busy", busy4, 0);

    cap0 = cap_cnt;
    cmd(2'b11, 1000);
    repeat (10) tick();
    chk("halt_pre_ce", clk_ce, 1);
    halt_req = 1;
    tick();
    halt_req = 0;
`ifdef HALT_TRIGGER_EN
    chk("halt_ce", clk_ce, 0); chk("halt_flag", halted, 1);
    repeat (3) tick();
    chk("halt_settle_cap", capture, 0);
    tick();
    chk("halt_cap", capture, 1); chk("halt_cycles", cycles_run, 10);
`else
    chk("nohalt_ce", clk_ce, 1); chk("nohalt_flag", halted, 0);
    repeat (989) tick();
    chk("nohalt_last_ce", clk_ce, 1);
    tick();
    chk("nohalt_end_ce", clk_ce, 0); chk("nohalt_cycles", cycles_run, 1000);
    repeat (3) tick();
    chk("nohalt_settle_cap", capture, 0);
    tick();
    chk("nohalt_cap", capture, 1); chk("nohalt_flag2", halted, 0);
`endif
    tick();
    capture_done = 1;
    tick();
    capture_done = 0;
    chk("halt_idle", busy, 0); chk("halt_cap_count", cap_cnt - cap0, 1);

    cmd(2'b11, 1);
    tick(); tick(); tick();
    chk("rsts_busy_pre", busy, 1);
    #1 rst = 1;
    #1;
    chk("rsts_ce", clk_ce, 0); chk("rsts_cap", capture, 0); chk("rsts_busy", busy, 0); chk("rsts_ready", cmd_ready, 0);
    rst = 0;
    cap0 = cap_cnt;
    repeat (6) tick();
    chk("rsts_idle", busy, 0); chk("rsts_ready2", cmd_ready, 1); chk("rsts_nocap", cap_cnt - cap0, 0);

    cmd(2'b01, 0);
    repeat (3) tick();
    chk("rstr_ce_pre", clk_ce, 1);
    #1 rst = 1;
    #1;
    chk("rstr_ce", clk_ce, 0); chk("rstr_cycles", cycles_run, 0);
    rst = 0;
    tick();
    chk("rstr_busy", busy, 0); chk("rstr_halted", halted, 0);
    cmd(2'b10, 2);
    chk("rstr_step_ce0", clk_ce, 0);
    tick(); chk("rstr_step_ce1", clk_ce, 1);
    tick(); chk("rstr_step_ce2", clk_ce, 1);
    tick();
    chk("rstr_step_end", clk_ce, 0); chk("rstr_step_busy", busy, 0); chk("rstr_step_cycles", cycles_run, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/step_clock_ctrl.md
# step_clock_ctrl

Fabric-side sequencer for the gated design clock used in readback-capture experiments. It drives the CE of the design clock's BUFGCE to run the design freely, or to advance it by an exact number of cycles. After a stepped run it can settle and then issue a single-cycle capture pulse toward the CAPTUREE2 / readback path. It then waits for the readback engine to acknowledge before it accepts new work.

## Interface
- CNT_W, default 32: width of step count and cycle counter.
- SETTLE_CYCLES, default 4: idle cycles between CE deassertion and the capture pulse; legal range 1..255.
- clk  in  1  free-running controller clock; same clock as the BUFGCE input.
- rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command strobe.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  command: 00 STOP, 01 RUN, 10 STEP, 11 STEP_CAPTURE.
- cmd_count  in  CNT_W  cycle count for STEP and STEP_CAPTURE; ignored otherwise.
- halt_req  in  1  external breakpoint, level-sensitive.
- clk_ce  out  1  registered CE to the BUFGCE.
- capture  out  1  one-cycle capture pulse.
- capture_done  in  1  readback engine acknowledge, pulse or level.
- busy  out  1  high in every state except IDLE.
- halted  out  1  sticky; set when halt_req ended a run. Cleared on the next accepted command.
- cycles_run  out  CNT_W  number of cycles clk_ce has been high since the last RUN or STEP accept. Saturates at all-ones.

## Operation
- States:
  - IDLE
  - RUN
  - STEP
  - SETTLE
  - CAPTURE
  - WAIT_ACK
- cmd_ready is 1 in IDLE and RUN and 0 in all other states.
- From IDLE:
  - STOP: accepted, no state change.
  - RUN: go to RUN and clear cycles_run.
  - STEP or STEP_CAPTURE with N>0: load down-counter with N, go to STEP, clear cycles_run, latch the capture flag.
  - STEP with N=0: accepted, stays in IDLE, clk_ce never asserts.
  - STEP_CAPTURE with N=0: goes directly to SETTLE (capture without advancing).
- In RUN:
  - STOP: go to IDLE.
  - RUN: accepted and ignored; the counter continues.
  - STEP or STEP_CAPTURE: handled as from IDLE, and cycles_run is cleared.
- In STEP:
  - clk_ce is high for exactly N consecutive cycles.
  - When the down-counter reaches zero, go to SETTLE if the capture flag is set, otherwise to IDLE.
- In SETTLE: count SETTLE_CYCLES cycles, then go to CAPTURE.
- In CAPTURE: capture=1 for exactly one cycle, then go to WAIT_ACK.
- In WAIT_ACK: stay until capture_done=1, then go to IDLE. capture_done is ignored in every other state.
- cycles_run increments on every cycle where clk_ce=1, and holds at 2^CNT_W−1.

## Timing
- Reset values: clk_ce=0, capture=0, cmd_ready=0 while rst is high, busy=0, halted=0, cycles_run=0, state=IDLE.
- cmd_ready=1 the first clock after rst is released.
- Reset mid-operation immediately forces clk_ce=0. Any pending capture is dropped.
- Command accepted at edge k: clk_ce first goes high after edge k+1. This is a one-cycle latency because clk_ce is registered.
- STEP N: clk_ce is high for cycles k+1..k+N. busy falls at k+N+1 when no capture is requested.
- STEP_CAPTURE N: clk_ce is low from k+N+1, and capture is high for the cycle after the SETTLE_CYCLES settle cycles.
- STOP in RUN accepted at edge k: clk_ce is low from edge k+1.
- cycles_run becomes valid one cycle after clk_ce falls.
- A capture_done that arrives in the same cycle as the capture pulse is not accepted; it is only recognised in WAIT_ACK.

## Configuration
- HALT_TRIGGER_EN defined:
  - halt_req sampled high in RUN or STEP forces clk_ce=0 on the next edge and sets halted.
  - The state then goes to IDLE. If the STEP had the capture flag set, it goes to SETTLE instead.
  - halt_req has priority over a command presented in the same cycle. The command is not accepted.
- HALT_TRIGGER_EN undefined: halt_req is ignored, halted is tied to 0, and the halt logic is removed.

## Test plan
- Reset release, then STEP N=5 → clk_ce high for exactly 5 cycles starting 1 cycle after accept; cycles_run=5; busy low the next cycle; capture never asserted.
- STEP_CAPTURE N=3, SETTLE_CYCLES=4, capture_done 6 cycles after the pulse → clk_ce high 3 cycles, low 4 cycles, then capture=1 for one cycle. busy stays high until the cycle after capture_done, and cmd_ready stays 0 throughout.
- RUN, STOP after 100 cycles → cycles_run=100, clk_ce=0 one cycle after the STOP accept. Then STEP N=0 → clk_ce stays 0 and cycles_run=0.
- RUN with CNT_W=4 for 40 cycles → cycles_run saturates at 15. A STEP N=2 issued during RUN clears the counter to 0 and ends at 2.
- HALT_TRIGGER_EN defined: STEP_CAPTURE N=1000, halt_req pulsed after 10 CE cycles → clk_ce falls within 1 cycle, halted=1, capture still issued after the settle. With the macro undefined, the same stimulus gives all 1000 cycles and halted=0.
- rst asserted during SETTLE and during RUN → clk_ce and capture go low immediately with no clock edge; the FSM is in IDLE after release and a new STEP N=2 behaves normally.
